// File: rtl/key_load_ctrl_if.sv
// Byte-stream link from the host into the key load sequencer (valid/ready handshake).
interface key_load_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/key_load_ctrl.sv
// Recognises a key frame (header, 4 key bytes LSB first, XOR checksum) and writes the
// key bytes into the key register, reporting success, checksum error or inter-byte timeout.
//
// state | meaning
// IDLE  | waiting for header byte, other bytes dropped
// LOAD  | receiving key bytes 0..3, each written to the key register
// CSUM  | waiting for checksum byte
// RESP  | one cycle, rx_ready low, reports load_done or err_csum
module key_load_ctrl #(
  parameter logic [7:0] HDR_BYTE = 8'h4B,
  parameter int         TIMEOUT  = 50000,
  parameter int         TO_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  key_load_ctrl_if.slave        rx,
  output logic [7:0]            kr_din_o,
  output logic                  kr_en_o,
  output logic [1:0]            kr_in_sel_o,
  output logic                  key_ok_o,
  output logic                  load_done_o,
  output logic                  err_csum_o,
  output logic                  err_timeout_o
);

  typedef enum logic [1:0] {IDLE, LOAD, CSUM, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      acc_q, acc_d;
  logic            match_q, match_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            key_ok_q, key_ok_d;
  logic            err_to_q, err_to_d;
  logic            kr_en_q, kr_en_d;
  logic [7:0]      kr_din_q, kr_din_d;
  logic [1:0]      kr_sel_q, kr_sel_d;
  logic            rx_ready;
  logic            accept;

  // rx_ready is gated by reset so it reads low in the reset cycle itself
  assign rx_ready    = (state_q != RESP) && !reset;
  assign rx.rx_ready = rx_ready;
  assign accept      = rx.rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      match_q  <= 1'b0;
      to_cnt_q <= '0;
      key_ok_q <= 1'b0;
      err_to_q <= 1'b0;
      kr_en_q  <= 1'b0;
      kr_din_q <= '0;
      kr_sel_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      match_q  <= match_d;
      to_cnt_q <= to_cnt_d;
      key_ok_q <= key_ok_d;
      err_to_q <= err_to_d;
      kr_en_q  <= kr_en_d;
      kr_din_q <= kr_din_d;
      kr_sel_q <= kr_sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    match_d  = match_q;
    to_cnt_d = to_cnt_q;
    key_ok_d = key_ok_q;
    err_to_d = 1'b0;
    kr_en_d  = 1'b0;
    kr_din_d = kr_din_q;
    kr_sel_d = kr_sel_q;
    case (state_q)
      IDLE: begin
        if (accept && rx.rx_data == HDR_BYTE) begin
          state_d  = LOAD;
          idx_d    = '0;
          acc_d    = '0;
          key_ok_d = 1'b0;
          to_cnt_d = '0;
        end
      end
      LOAD, CSUM: begin
        if (accept) begin
          to_cnt_d = '0;
          if (state_q == LOAD) begin
            acc_d    = acc_q ^ rx.rx_data;
            kr_en_d  = 1'b1;
            kr_din_d = rx.rx_data;
            kr_sel_d = idx_q;
            idx_d    = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = CSUM;
          end else begin
            match_d = (rx.rx_data == acc_q);
            state_d = RESP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // an accepted byte in this same cycle takes the branch above instead
          state_d  = IDLE;
          err_to_d = 1'b1;
          key_ok_d = 1'b0;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (match_q) key_ok_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign kr_din_o      = kr_din_q;
  assign kr_en_o       = kr_en_q;
  assign kr_in_sel_o   = kr_sel_q;
  assign key_ok_o      = key_ok_q;
  assign load_done_o   = (state_q == RESP) && match_q;
  assign err_csum_o    = (state_q == RESP) && !match_q;
  assign err_timeout_o = err_to_q;

endmodule
